pri_arbiter_n: RTL and testbench

//  Parametrised, registered successor to the 4:2 priority encoder. Latches N sticky

---
 rtl/pri_arbiter_n_pkg.sv | 29 ++
 rtl/pri_pick_n.sv | 52 +++++
 rtl/pri_arbiter_n.sv | 119 +++++++++++
 tb/tb_pri_arbiter_n.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pri_arbiter_n_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pri_arbiter_n_pkg                                               |
// | Brief  : Shared state encoding, mode constants and index helper for the  |
// |          registered N-input priority / round-robin arbiter.              |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package pri_arbiter_n_pkg;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } pri_state_e;

  // Arbitration modes
  localparam int PRI_FIXED = 0;
  localparam int PRI_RR    = 1;

  // (a + b) mod n for a, b in [0, n-1]; avoids a general modulo operator
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pri_pick_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pri_pick_n                                                      |
// | Brief  : Combinational winner picker. Fixed mode returns the highest set |
// |          index; rotating mode returns the first set bit scanning upward  |
// |          from start, modulo N.                                           |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module pri_pick_n
  import pri_arbiter_n_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  input  logic         rr,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         any
);

  // Scan the request vector and select one winner index
  always_comb begin
    idx = '0;
    any = |vec;
    if (rr) begin
      // Walk from the farthest offset down to offset 0 so the closest set
      // bit at or above start is the last (and therefore kept) assignment.
      for (int k = N - 1; k >= 0; k--) begin
        if (vec[wrap_add(int'(start), k, N)]) begin
          idx = W'(wrap_add(int'(start), k, N));
        end
      end
    end else begin
      // Ascending scan: the highest set index overwrites all lower ones.
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  // Decode the winner index; stays all-zero when nothing is requested
  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = any && (idx == W'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/pri_arbiter_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : pri_arbiter_n                                                   |
// | Brief  : Registered N-input arbiter with sticky request latching and a   |
// |          valid/ready grant port. Fixed highest-index or round-robin.     |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module pri_arbiter_n
  import pri_arbiter_n_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = $clog2(N),
  parameter int RR_MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [N-1:0] pending,
  output logic         dis
);

  pri_state_e   r_state,   w_state_nx;
  logic [N-1:0] r_pending, w_pending_nx;
  logic         r_valid,   w_valid_nx;
  logic [W-1:0] r_idx,     w_idx_nx;
  logic [N-1:0] r_onehot,  w_onehot_nx;
  logic [W-1:0] r_rr_ptr,  w_rr_ptr_nx;

  logic         w_rr;
  logic         w_accept;
  logic [N-1:0] w_clr;
  logic [W-1:0] w_pick_idx;
  logic [N-1:0] w_pick_onehot;
  logic         w_pick_any;

  assign w_rr = (RR_MODE == PRI_RR);

  // Arbitration always looks at the registered pending vector, never raw req
  pri_pick_n #(
    .N (N),
    .W (W)
  ) u_pick (
    .vec    (r_pending),
    .start  (r_rr_ptr),
    .rr     (w_rr),
    .idx    (w_pick_idx),
    .onehot (w_pick_onehot),
    .any    (w_pick_any)
  );

  // Accepted winner is removed from pending; a same-cycle request re-sets it
  assign w_accept     = r_valid & out_ready;
  assign w_clr        = w_accept ? r_onehot : '0;
  assign w_pending_nx = (r_pending & ~w_clr) | req;

  // Next-state and output-register logic; grant fields hold unless loaded
  always_comb begin
    w_state_nx  = r_state;
    w_valid_nx  = r_valid;
    w_idx_nx    = r_idx;
    w_onehot_nx = r_onehot;
    w_rr_ptr_nx = r_rr_ptr;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_idx_nx    = w_pick_idx;
          w_onehot_nx = w_pick_onehot;
          w_valid_nx  = 1'b1;
          w_state_nx  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (out_ready) begin
          w_valid_nx = 1'b0;
          w_state_nx = ST_IDLE;
          // Fixed mode leaves the pointer parked at zero
          if (RR_MODE != PRI_FIXED) begin
            w_rr_ptr_nx = (r_idx == W'(N - 1)) ? '0 : r_idx + W'(1);
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  // State, pending and grant registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_onehot  <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_pending <= w_pending_nx;
      r_valid   <= w_valid_nx;
      r_idx     <= w_idx_nx;
      r_onehot  <= w_onehot_nx;
      r_rr_ptr  <= w_rr_ptr_nx;
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign pending    = r_pending;
  assign dis        = ~|r_pending & ~r_valid;

endmodule
`default_nettype wire

// File: tb/tb_pri_arbiter_n.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_pri_arbiter_n                                                |
// | Brief  : Directed self-checking bench for pri_arbiter_n: fixed N=8,      |
// |          round-robin N=8 and round-robin N=5 instances.                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_pri_arbiter_n;

  logic clk;
  logic rst_n;

  // Fixed-priority, N=8
  logic [7:0] req_f;
  logic       ready_f;
  logic       valid_f;
  logic [2:0] idx_f;
  logic [7:0] oh_f;
  logic [7:0] pend_f;
  logic       dis_f;

  // Round-robin, N=8
  logic [7:0] req_r;
  logic       ready_r;
  logic       valid_r;
  logic [2:0] idx_r;
  logic [7:0] oh_r;
  logic [7:0] pend_r;
  logic       dis_r;

  // Round-robin, N=5
  logic [4:0] req_5;
  logic       ready_5;
  logic       valid_5;
  logic [2:0] idx_5;
  logic [4:0] oh_5;
  logic [4:0] pend_5;
  logic       dis_5;

  int n_pass;
  int n_total;

  pri_arbiter_n #(.N(8), .RR_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req_f), .out_ready(ready_f),
    .out_valid(valid_f), .out_idx(idx_f), .out_onehot(oh_f),
    .pending(pend_f), .dis(dis_f)
  );

  pri_arbiter_n #(.N(8), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req_r), .out_ready(ready_r),
    .out_valid(valid_r), .out_idx(idx_r), .out_onehot(oh_r),
    .pending(pend_r), .dis(dis_r)
  );

  pri_arbiter_n #(.N(5), .RR_MODE(1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .req(req_5), .out_ready(ready_5),
    .out_valid(valid_5), .out_idx(idx_5), .out_onehot(oh_5),
    .pending(pend_5), .dis(dis_5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock, then settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_fix [3];
    int exp_rr5 [4];
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    req_f = '0; ready_f = 1'b0;
    req_r = '0; ready_r = 1'b0;
    req_5 = '0; ready_5 = 1'b0;

    // Power-on reset state
    #12;
    check("rst_valid",  32'(valid_f), 32'd0);
    check("rst_idx",    32'(idx_f),   32'd0);
    check("rst_onehot", 32'(oh_f),    32'd0);
    check("rst_pend",   32'(pend_f),  32'd0);
    check("rst_dis",    32'(dis_f),   32'd1);
    check("rst_dis_rr5", 32'(dis_5),  32'd1);
    tick();
    rst_n = 1'b1;

    // Async reset in the middle of a grant with everything pending
    req_f = 8'hFF; ready_f = 1'b0;
    tick();
    tick();
    check("t1_pre_valid", 32'(valid_f), 32'd1);
    check("t1_pre_idx",   32'(idx_f),   32'd7);
    check("t1_pre_pend",  32'(pend_f),  32'hFF);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_valid",  32'(valid_f), 32'd0);
    check("t1_async_idx",    32'(idx_f),   32'd0);
    check("t1_async_onehot", 32'(oh_f),    32'd0);
    check("t1_async_pend",   32'(pend_f),  32'd0);
    check("t1_async_dis",    32'(dis_f),   32'd1);
    req_f = '0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    tick();
    check("t1_post_valid", 32'(valid_f), 32'd0);
    check("t1_post_dis",   32'(dis_f),   32'd1);

    // Fixed priority: one-cycle burst 0010_1001 drains as 5, 3, 0
    exp_fix = '{5, 3, 0};
    req_f = 8'b0010_1001; ready_f = 1'b1;
    tick();
    req_f = '0;
    check("t2_pend", 32'(pend_f), 32'h29);
    check("t2_no_early_grant", 32'(valid_f), 32'd0);
    for (int g = 0; g < 3; g++) begin
      tick();
      check("t2_valid",  32'(valid_f), 32'd1);
      check("t2_idx",    32'(idx_f),   32'(exp_fix[g]));
      check("t2_onehot", 32'(oh_f),    32'(1 << exp_fix[g]));
      tick();
      check("t2_bubble", 32'(valid_f), 32'd0);
    end
    check("t2_dis", 32'(dis_f), 32'd1);
    ready_f = 1'b0;

    // Backpressure: idx 6 held for 5 cycles while req[7] pulses
    req_f = 8'h40;
    tick();
    req_f = '0;
    tick();
    check("t3_grant6", 32'(idx_f), 32'd6);
    for (int c = 0; c < 5; c++) begin
      req_f = (c == 1) ? 8'h80 : 8'h00;
      tick();
      check("t3_hold_idx",   32'(idx_f),   32'd6);
      check("t3_hold_valid", 32'(valid_f), 32'd1);
    end
    req_f = '0;
    check("t3_pend", 32'(pend_f), 32'hC0);
    ready_f = 1'b1;
    tick();
    check("t3_acc_valid", 32'(valid_f), 32'd0);
    check("t3_acc_pend",  32'(pend_f),  32'h80);
    tick();
    check("t3_next_valid", 32'(valid_f), 32'd1);
    check("t3_next_idx",   32'(idx_f),   32'd7);
    tick();
    check("t3_dis", 32'(dis_f), 32'd1);
    ready_f = 1'b0;

    // Set wins over clear on the accept cycle of the same index
    req_f = 8'h04;
    tick();
    req_f = '0;
    tick();
    check("t5_grant2", 32'(idx_f), 32'd2);
    ready_f = 1'b1;
    req_f = 8'h04;
    tick();
    req_f = '0;
    check("t5_acc_valid", 32'(valid_f), 32'd0);
    check("t5_pend_kept", 32'(pend_f),  32'h04);
    tick();
    check("t5_regrant_valid", 32'(valid_f), 32'd1);
    check("t5_regrant_idx",   32'(idx_f),   32'd2);
    tick();
    check("t5_pend_clear", 32'(pend_f), 32'd0);
    check("t5_dis",        32'(dis_f),  32'd1);
    ready_f = 1'b0;

    // Round-robin N=8, all requests held: 0..7 then wrap to 0
    req_r = 8'hFF; ready_r = 1'b1;
    tick();
    for (int g = 0; g < 9; g++) begin
      tick();
      check("t4_valid",  32'(valid_r), 32'd1);
      check("t4_idx",    32'(idx_r),   32'(g % 8));
      check("t4_onehot", 32'(oh_r),    32'(1 << (g % 8)));
      tick();
      check("t4_bubble", 32'(valid_r), 32'd0);
    end
    req_r = '0;

    // Round-robin N=5, requests 0 and 4 held: 0,4,0,4
    exp_rr5 = '{0, 4, 0, 4};
    req_5 = 5'b10001; ready_5 = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      tick();
      check("t6_valid", 32'(valid_5), 32'd1);
      check("t6_idx",   32'(idx_5),   32'(exp_rr5[g]));
      check("t6_range", 32'(idx_5 <= 3'd4), 32'd1);
      tick();
    end
    req_5 = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
